rename_dispatch_queue: RTL and testbench

//  In-order dispatch queue directly downstream of the front-end RAT (AR stage).
//  - Accepts up to ISSUE_WIDTH_MAX renamed instrs/cycle; holds them until the reservation stations accept.
//  - Tracks per-source readiness: sources of type ROB wake up on CDB robid matches.
//  - Flushes completely on branch clear.

---
 rtl/rename_dispatch_queue_pkg.sv | 31 +++
 rtl/rename_dispatch_queue_wakeup.sv | 24 ++
 rtl/rename_dispatch_queue.sv | 175 +++++++++++++++++
 tb/tb_rename_dispatch_queue.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_dispatch_queue_pkg.sv
// Shared constants and entry layout for the rename dispatch queue.
// Entry tags are RAT-renamed sources; ROB-typed sources wait for CDB.
package rename_dispatch_queue_pkg;

    localparam int ISSUE_WIDTH_MAX       = 2;
    localparam int NUM_SRCS              = 2;
    localparam int RAT_RENAME_DATA_WIDTH = 6;
    localparam int ROB_SIZE_CLOG         = 5;
    localparam int OPCODE_LEN            = 7;
    localparam int SRC_LEN               = 5;
    localparam int DQ_DEPTH              = 8;
    localparam int CDB_WIDTH             = 2;

    localparam int IW    = ISSUE_WIDTH_MAX;
    localparam int RRDW  = RAT_RENAME_DATA_WIDTH;
    localparam int PTR_W = $clog2(DQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic PRF_DATA_TYPE = 1'b1;
    localparam logic ROB_DATA_TYPE = 1'b0;

    typedef struct packed {
        logic [OPCODE_LEN-1:0]              opcode;
        logic [SRC_LEN-1:0]                 rd;
        logic [NUM_SRCS-1:0][RRDW-1:0]      src_renamed;
        logic [NUM_SRCS-1:0]                src_type;
        logic [NUM_SRCS-1:0]                src_rdy;
        logic [ROB_SIZE_CLOG-1:0]           robid;
    } dq_entry_t;

endpackage

// File: rtl/rename_dispatch_queue_wakeup.sv
// CDB tag comparator for one source operand.
// PRF-typed sources never match; they are ready at rename.
module dq_cdb_wakeup
    import rename_dispatch_queue_pkg::*;
(
    input  logic [RRDW-1:0]                   tag_i,
    input  logic                              type_i,
    input  logic [CDB_WIDTH-1:0]              cdb_val_i,
    input  logic [CDB_WIDTH*ROB_SIZE_CLOG-1:0] cdb_robid_i,
    output logic                              match_o
);

    always_comb begin
        match_o = 1'b0;
        for (int c = 0; c < CDB_WIDTH; c++) begin
            if (cdb_val_i[c] &&
                tag_i == RRDW'(cdb_robid_i[c*ROB_SIZE_CLOG +: ROB_SIZE_CLOG]))
                match_o = 1'b1;
        end
        if (type_i == PRF_DATA_TYPE)
            match_o = 1'b0;
    end

endmodule

// File: rtl/rename_dispatch_queue.sv
// In-order dispatch queue between RAT and reservation stations.
// Compacts valid lanes on enqueue, wakes ROB sources from the CDB.
module rename_dispatch_queue
    import rename_dispatch_queue_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic [IW-1:0]                      in_val,
    input  logic [IW*OPCODE_LEN-1:0]           in_opcode,
    input  logic [IW*SRC_LEN-1:0]              in_rd,
    input  logic [IW*NUM_SRCS*RRDW-1:0]        in_src_renamed,
    input  logic [IW*NUM_SRCS-1:0]             in_src_type,
    input  logic [IW*ROB_SIZE_CLOG-1:0]        in_robid,
    output logic                               in_ready,
    input  logic [CDB_WIDTH-1:0]               cdb_val,
    input  logic [CDB_WIDTH*ROB_SIZE_CLOG-1:0] cdb_robid,
    input  logic                               branch_clear,
    output logic [IW-1:0]                      out_val,
    output logic [IW*OPCODE_LEN-1:0]           out_opcode,
    output logic [IW*SRC_LEN-1:0]              out_rd,
    output logic [IW*NUM_SRCS*RRDW-1:0]        out_src_renamed,
    output logic [IW*NUM_SRCS-1:0]             out_src_type,
    output logic [IW*ROB_SIZE_CLOG-1:0]        out_robid,
    output logic [IW*NUM_SRCS-1:0]             out_src_rdy,
    input  logic [IW-1:0]                      rs_accept
);

    dq_entry_t [DQ_DEPTH-1:0]      entries_q, entries_d;
    logic [DQ_DEPTH-1:0]           valid_q, valid_d;
    logic [PTR_W-1:0]              head_q, head_d;
    logic [PTR_W-1:0]              tail_q, tail_d;
    logic [CNT_W-1:0]              count_q, count_d;

    logic [DQ_DEPTH*NUM_SRCS-1:0]  st_match;
    logic [IW*NUM_SRCS-1:0]        in_match;
    dq_entry_t [IW-1:0]            new_entry;
    logic [PTR_W-1:0]              slot [IW];
    logic [PTR_W-1:0]              out_idx [IW];
    logic [IW-1:0]                 take;
    logic [CNT_W-1:0]              n_enq, n_deq;
    logic                          do_enq;
    logic                          chain;

    for (genvar k = 0; k < DQ_DEPTH; k++) begin : g_st
        for (genvar s = 0; s < NUM_SRCS; s++) begin : g_src
            dq_cdb_wakeup u_wk (
                .tag_i       (entries_q[k].src_renamed[s]),
                .type_i      (entries_q[k].src_type[s]),
                .cdb_val_i   (cdb_val),
                .cdb_robid_i (cdb_robid),
                .match_o     (st_match[k*NUM_SRCS+s])
            );
        end
    end

    for (genvar i = 0; i < IW; i++) begin : g_in
        for (genvar s = 0; s < NUM_SRCS; s++) begin : g_src
            dq_cdb_wakeup u_wk (
                .tag_i       (in_src_renamed[(i*NUM_SRCS+s)*RRDW +: RRDW]),
                .type_i      (in_src_type[i*NUM_SRCS+s]),
                .cdb_val_i   (cdb_val),
                .cdb_robid_i (cdb_robid),
                .match_o     (in_match[i*NUM_SRCS+s])
            );
        end
    end

    // Registered count only: no dequeue-to-enqueue combinational path.
    assign in_ready = (count_q <= CNT_W'(DQ_DEPTH - IW));
    assign do_enq   = in_ready & ~branch_clear;

    always_comb begin
        n_enq = '0;
        for (int i = 0; i < IW; i++) begin
            slot[i] = tail_q + n_enq[PTR_W-1:0];
            new_entry[i].opcode = in_opcode[i*OPCODE_LEN +: OPCODE_LEN];
            new_entry[i].rd     = in_rd[i*SRC_LEN +: SRC_LEN];
            new_entry[i].robid  = in_robid[i*ROB_SIZE_CLOG +: ROB_SIZE_CLOG];
            for (int s = 0; s < NUM_SRCS; s++) begin
                new_entry[i].src_renamed[s] =
                    in_src_renamed[(i*NUM_SRCS+s)*RRDW +: RRDW];
                new_entry[i].src_type[s] = in_src_type[i*NUM_SRCS+s];
                new_entry[i].src_rdy[s]  = in_src_type[i*NUM_SRCS+s] |
                                           in_match[i*NUM_SRCS+s];
            end
            if (in_val[i])
                n_enq = n_enq + CNT_W'(1);
        end
    end

    always_comb begin
        n_deq           = '0;
        chain           = 1'b1;
        take            = '0;
        out_val         = '0;
        out_opcode      = '0;
        out_rd          = '0;
        out_src_renamed = '0;
        out_src_type    = '0;
        out_robid       = '0;
        out_src_rdy     = '0;
        for (int i = 0; i < IW; i++) begin
            out_idx[i] = head_q + PTR_W'(i);
            out_val[i] = (count_q > CNT_W'(i));
            take[i]    = chain & out_val[i] & rs_accept[i];
            chain      = take[i];
            if (take[i])
                n_deq = n_deq + CNT_W'(1);
            out_opcode[i*OPCODE_LEN +: OPCODE_LEN] =
                entries_q[out_idx[i]].opcode;
            out_rd[i*SRC_LEN +: SRC_LEN] = entries_q[out_idx[i]].rd;
            out_robid[i*ROB_SIZE_CLOG +: ROB_SIZE_CLOG] =
                entries_q[out_idx[i]].robid;
            for (int s = 0; s < NUM_SRCS; s++) begin
                out_src_renamed[(i*NUM_SRCS+s)*RRDW +: RRDW] =
                    entries_q[out_idx[i]].src_renamed[s];
                out_src_type[i*NUM_SRCS+s] =
                    entries_q[out_idx[i]].src_type[s];
                out_src_rdy[i*NUM_SRCS+s] =
                    entries_q[out_idx[i]].src_rdy[s] |
                    st_match[int'(out_idx[i])*NUM_SRCS+s];
            end
        end
    end

    always_comb begin
        entries_d = entries_q;
        valid_d   = valid_q;
        for (int k = 0; k < DQ_DEPTH; k++) begin
            for (int s = 0; s < NUM_SRCS; s++) begin
                if (valid_q[k] && st_match[k*NUM_SRCS+s])
                    entries_d[k].src_rdy[s] = 1'b1;
            end
        end
        for (int i = 0; i < IW; i++) begin
            if (take[i])
                valid_d[out_idx[i]] = 1'b0;
        end
        // Enqueue slots are free whenever in_ready, so never collide with deq.
        if (do_enq) begin
            for (int i = 0; i < IW; i++) begin
                if (in_val[i]) begin
                    entries_d[slot[i]] = new_entry[i];
                    valid_d[slot[i]]   = 1'b1;
                end
            end
        end
        head_d  = head_q + n_deq[PTR_W-1:0];
        tail_d  = do_enq ? tail_q + n_enq[PTR_W-1:0] : tail_q;
        count_d = count_q + (do_enq ? n_enq : '0) - n_deq;
        if (branch_clear) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries_q <= '0;
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            valid_q   <= valid_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_rename_dispatch_queue.sv
// Randomized and directed bench for rename_dispatch_queue.
// Reference model: a FIFO queue of instructions with readiness flags.
module tb_rename_dispatch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  in_val;
    logic [13:0] in_opcode;
    logic [9:0]  in_rd;
    logic [23:0] in_src_renamed;
    logic [3:0]  in_src_type;
    logic [9:0]  in_robid;
    logic        in_ready;
    logic [1:0]  cdb_val;
    logic [9:0]  cdb_robid;
    logic        branch_clear;
    logic [1:0]  out_val;
    logic [13:0] out_opcode;
    logic [9:0]  out_rd;
    logic [23:0] out_src_renamed;
    logic [3:0]  out_src_type;
    logic [9:0]  out_robid;
    logic [3:0]  out_src_rdy;
    logic [1:0]  rs_accept;

    rename_dispatch_queue dut (
        .clk             (clk),
        .rst             (rst),
        .in_val          (in_val),
        .in_opcode       (in_opcode),
        .in_rd           (in_rd),
        .in_src_renamed  (in_src_renamed),
        .in_src_type     (in_src_type),
        .in_robid        (in_robid),
        .in_ready        (in_ready),
        .cdb_val         (cdb_val),
        .cdb_robid       (cdb_robid),
        .branch_clear    (branch_clear),
        .out_val         (out_val),
        .out_opcode      (out_opcode),
        .out_rd          (out_rd),
        .out_src_renamed (out_src_renamed),
        .out_src_type    (out_src_type),
        .out_robid       (out_robid),
        .out_src_rdy     (out_src_rdy),
        .rs_accept       (rs_accept)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]      op;
        logic [4:0]      rd;
        logic [1:0][5:0] tag;
        logic [1:0]      typ;
        logic [1:0]      rdy;
        logic [4:0]      rob;
    } m_t;

    m_t         mq[$];
    int         errors = 0;
    int         checks = 0;
    logic [4:0] rob_ctr = 5'd0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cm(input logic [5:0] tag);
        logic m;
        m = 1'b0;
        for (int c = 0; c < 2; c++)
            if (cdb_val[c] && tag == {1'b0, cdb_robid[c*5 +: 5]})
                m = 1'b1;
        return m;
    endfunction

    function automatic m_t lane_in(input int i);
        m_t m;
        m.op  = in_opcode[i*7 +: 7];
        m.rd  = in_rd[i*5 +: 5];
        m.rob = in_robid[i*5 +: 5];
        for (int s = 0; s < 2; s++) begin
            m.tag[s] = in_src_renamed[(i*2+s)*6 +: 6];
            m.typ[s] = in_src_type[i*2+s];
            m.rdy[s] = m.typ[s] | cm(m.tag[s]);
        end
        return m;
    endfunction

    function automatic m_t lane_out(input int i);
        m_t m;
        m.op  = out_opcode[i*7 +: 7];
        m.rd  = out_rd[i*5 +: 5];
        m.rob = out_robid[i*5 +: 5];
        for (int s = 0; s < 2; s++) begin
            m.tag[s] = out_src_renamed[(i*2+s)*6 +: 6];
            m.typ[s] = out_src_type[i*2+s];
            m.rdy[s] = out_src_rdy[i*2+s];
        end
        return m;
    endfunction

    task automatic set_lane(input int i, input logic [5:0] t0,
                            input logic [5:0] t1, input logic [1:0] typ);
        in_opcode[i*7 +: 7]          = 7'($urandom);
        in_rd[i*5 +: 5]              = 5'($urandom);
        in_src_renamed[(i*2)*6 +: 6] = t0;
        in_src_renamed[(i*2+1)*6 +: 6] = t1;
        in_src_type[i*2 +: 2]        = typ;
        in_robid[i*5 +: 5]           = rob_ctr;
        rob_ctr                      = rob_ctr + 5'd1;
    endtask

    task automatic idle();
        in_val       = 2'b00;
        cdb_val      = 2'b00;
        rs_accept    = 2'b00;
        branch_clear = 1'b0;
    endtask

    // Check current outputs against the model, then advance one clock.
    task automatic step(input string tag);
        m_t nq[$];
        m_t e;
        int n;
        #1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(mq.size() <= 6));
        chk({tag, "_out_val"}, 64'(out_val),
            64'({mq.size() > 1, mq.size() > 0}));
        for (int i = 0; i < 2; i++) begin
            if (mq.size() > i) begin
                e = mq[i];
                for (int s = 0; s < 2; s++)
                    e.rdy[s] = e.rdy[s] | (!e.typ[s] & cm(e.tag[s]));
                chk($sformatf("%s_lane%0d", tag, i), 64'(lane_out(i)), 64'(e));
            end
        end
        nq = mq;
        if (branch_clear) begin
            nq.delete();
        end else begin
            n = 0;
            for (int i = 0; i < 2; i++)
                if (n == i && i < mq.size() && rs_accept[i])
                    n++;
            repeat (n) void'(nq.pop_front());
            foreach (nq[k])
                for (int s = 0; s < 2; s++)
                    if (!nq[k].typ[s] && cm(nq[k].tag[s]))
                        nq[k].rdy[s] = 1'b1;
            if (mq.size() <= 6)
                for (int i = 0; i < 2; i++)
                    if (in_val[i])
                        nq.push_back(lane_in(i));
        end
        @(posedge clk);
        @(negedge clk);
        mq = nq;
    endtask

    task automatic drain();
        idle();
        rs_accept = 2'b11;
        for (int i = 0; i < 6 && mq.size() > 0; i++)
            step("drain");
        rs_accept = 2'b00;
    endtask

    initial begin
        in_val         = '0;
        in_opcode      = '0;
        in_rd          = '0;
        in_src_renamed = '0;
        in_src_type    = '0;
        in_robid       = '0;
        cdb_val        = '0;
        cdb_robid      = '0;
        branch_clear   = 1'b0;
        rs_accept      = '0;
        repeat (2) @(negedge clk);
        chk("reset_out_val", 64'(out_val), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b1;

        // Two PRF-ready lanes appear the following cycle.
        rob_ctr = 5'd3;
        set_lane(0, 6'd1, 6'd2, 2'b11);
        set_lane(1, 6'd3, 6'd4, 2'b11);
        in_val = 2'b11;
        #1;
        chk("t1_not_same_cycle", 64'(out_val), 64'd0);
        step("t1_enq");
        idle();
        chk("t1_out_val", 64'(out_val), 64'h3);
        chk("t1_src_rdy", 64'(out_src_rdy), 64'hF);
        chk("t1_robid", 64'(out_robid), 64'({5'd4, 5'd3}));
        step("t1_hold");
        drain();

        // Fill to full; the extra cycle of inputs is dropped.
        for (int c = 0; c < 5; c++) begin
            set_lane(0, 6'(c), 6'(c + 1), 2'b11);
            set_lane(1, 6'(c + 2), 6'(c + 3), 2'b11);
            in_val = 2'b11;
            step("t2_fill");
        end
        idle();
        chk("t2_full", 64'(in_ready), 64'd0);
        rs_accept = 2'b10;
        step("t2_acc10");
        rs_accept = 2'b01;
        step("t2_acc01");
        chk("t2_after01", 64'(in_ready), 64'd0);
        rs_accept = 2'b11;
        step("t2_acc11");
        chk("t2_after11", 64'(in_ready), 64'd1);
        drain();

        // Pending ROB source woken by the CDB, bypass then stored.
        set_lane(0, 6'd2, 6'd9, 2'b01);
        in_val = 2'b01;
        step("t3_enq");
        idle();
        step("t3_wait");
        cdb_val   = 2'b01;
        cdb_robid = {5'd0, 5'd9};
        #1;
        chk("t3_bypass", 64'(out_src_rdy[1:0]), 64'h3);
        step("t3_cdb");
        idle();
        #1;
        chk("t3_stored", 64'(out_src_rdy[1:0]), 64'h3);
        drain();

        // CDB match in the enqueue cycle marks the source ready.
        set_lane(0, 6'd5, 6'd7, 2'b00);
        in_val    = 2'b01;
        cdb_val   = 2'b10;
        cdb_robid = {5'd5, 5'd0};
        step("t4_enq");
        idle();
        #1;
        chk("t4_rdy", 64'(out_src_rdy[1:0]), 64'h1);
        drain();

        // Random fill/drain across pointer wrap.
        for (int c = 0; c < 60; c++) begin
            set_lane(0, 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
                     2'($urandom));
            set_lane(1, 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
                     2'($urandom));
            in_val    = (c % 7 == 3) ? 2'b10 : 2'($urandom);
            cdb_val   = 2'($urandom);
            cdb_robid = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            rs_accept = 2'($urandom);
            step("t5_rand");
        end
        drain();

        // Branch clear overrides enqueue and dequeue.
        for (int c = 0; c < 2; c++) begin
            set_lane(0, 6'd1, 6'd1, 2'b11);
            set_lane(1, 6'd1, 6'd1, 2'b11);
            in_val = 2'b11;
            step("t6_fill");
        end
        set_lane(0, 6'd1, 6'd1, 2'b11);
        set_lane(1, 6'd1, 6'd1, 2'b11);
        in_val       = 2'b11;
        rs_accept    = 2'b11;
        branch_clear = 1'b1;
        step("t6_clear");
        idle();
        chk("t6_clr_val", 64'(out_val), 64'd0);
        chk("t6_clr_rdy", 64'(in_ready), 64'd1);
        step("t6_empty");

        // Asynchronous reset in the middle of a burst.
        for (int c = 0; c < 2; c++) begin
            set_lane(0, 6'd3, 6'd3, 2'b11);
            set_lane(1, 6'd3, 6'd3, 2'b11);
            in_val = 2'b11;
            step("t7_burst");
        end
        #2;
        rst = 1'b0;
        #1;
        chk("t7_rst_val", 64'(out_val), 64'd0);
        chk("t7_rst_rdy", 64'(in_ready), 64'd1);
        mq.delete();
        @(negedge clk);
        rst = 1'b1;
        idle();
        step("t7_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
